// File: rtl/cause_collector_pkg.sv
// Shared cause-vector index constants and widths for cause_collector.
package cause_pkg;

  localparam int unsigned CA_RESET  = 0;
  localparam int unsigned CA_ILL    = 1;
  localparam int unsigned CA_MISAF  = 2;
  localparam int unsigned CA_PFF    = 3;
  localparam int unsigned CA_PFLS   = 4;
  localparam int unsigned CA_MISALS = 5;
  localparam int unsigned CA_SYSC   = 6;
  localparam int unsigned CA_OVF    = 7;
  localparam int unsigned CA_EXT0   = 8;

  localparam int unsigned NUM_CA  = 23;
  localparam int unsigned NUM_EXT = 15;
  localparam int unsigned NUM_INT = CA_EXT0 - CA_ILL;

  localparam logic [NUM_CA-1:0] REPEAT_MASK = (NUM_CA'(1) << CA_PFF) | (NUM_CA'(1) << CA_PFLS);

endpackage

// File: rtl/cause_collector_irq_sync.sv
// Vectorised multi-flop synchroniser with rising-edge detect for external interrupt lines.
module irq_sync
  import cause_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned W           = NUM_EXT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      hist_q <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/cause_collector.sv
// Exception cause vector collector: reset cause, gated internal causes, pending external IRQs.
// Optional on-chip timer interrupt on ca[8] when CAUSE_TIMER_EN is defined.
module cause_collector
  import cause_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMER_W     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_INT-1:0]  int_cause,
  input  logic                instr_valid,
  input  logic [NUM_EXT-1:0]  ext_irq,
  input  logic                jisr,
  input  logic                tmr_we,
  input  logic [TIMER_W-1:0]  tmr_wdata,
  output logic [NUM_CA-1:0]   ca,
  output logic                rpt,
  output logic                ext_pending
);

  logic               rst_cause_q;
  logic [NUM_EXT-1:0] pend_q, pend_d;
  logic [NUM_EXT-1:0] rise;
  logic [NUM_EXT-1:0] set_vec;

  irq_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .W          (NUM_EXT)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .async_i(ext_irq),
    .rise_o (rise)
  );

`ifdef CAUSE_TIMER_EN
  logic [TIMER_W-1:0] cnt_q, cmp_q;
  logic               tmr_hit;

  assign tmr_hit = (cmp_q != '0) && (cnt_q == cmp_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      cmp_q <= '0;
    end else if (tmr_we) begin
      cmp_q <= tmr_wdata;
      cnt_q <= '0;
    end else if (tmr_hit) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign set_vec = rise | {{(NUM_EXT-1){1'b0}}, tmr_hit && !tmr_we};
`else
  logic unused_tmr;
  assign unused_tmr = ^{tmr_we, tmr_wdata};
  assign set_vec    = rise;
`endif

  // Set has priority over the jisr clear on the same edge.
  always_comb begin
    pend_d = (pend_q & ~{NUM_EXT{jisr}}) | set_vec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_cause_q <= 1'b1;
      pend_q      <= '0;
    end else begin
      if (jisr) rst_cause_q <= 1'b0;
      pend_q <= pend_d;
    end
  end

  assign ca          = {pend_q, int_cause & {NUM_INT{instr_valid}}, rst_cause_q};
  assign ext_pending = |pend_q;

  always_comb begin
    logic found;
    found = 1'b0;
    rpt   = 1'b0;
    for (int unsigned i = 0; i < NUM_CA; i++) begin
      if (!found && ca[i]) begin
        found = 1'b1;
        rpt   = REPEAT_MASK[i];
      end
    end
  end

endmodule
